// File: rtl/mem_duplex_module_pkg.sv
// Shared definitions for the duplex core-memory responder: widths, FSM
// state encoding, and the parity / syllable helpers.
package mem_duplex_module_pkg;

    localparam int SYL_W  = 13;  // data bits per syllable
    localparam int SYLP_W = 14;  // syllable plus parity bit
    localparam int WORD_W = 28;  // two syllables per word

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SENSE   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_REWRITE = 2'd3
    } state_e;

    // Parity bit that makes the total count of ones in {p, d} odd.
    function automatic logic odd_parity(input logic [SYL_W-1:0] d);
        return ~(^d);
    endfunction

    // True when a stored syllable (parity at its MSB) has odd total parity.
    function automatic logic parity_ok(input logic [SYLP_W-1:0] s);
        return ^s;
    endfunction

    // Extract syllable 0 (bits 13:0) or syllable 1 (bits 27:14) of a word.
    function automatic logic [SYLP_W-1:0] syl_slice(input logic [WORD_W-1:0] w,
                                                    input logic             sel);
        logic [SYLP_W-1:0] s;
        if (sel) begin
            s = w[27:14];
        end else begin
            s = w[13:0];
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_duplex_module_bank.sv
// One core-memory bank: 2^ADDR_W x 28-bit array with destructive syllable
// sensing (read into a sense register and clear) and syllable rewrite.
// The array itself is deliberately not reset.
module mem_core_bank
    import mem_duplex_module_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sense_en,
    input  logic              write_en,
    input  logic              sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [SYLP_W-1:0] wr_syl,
    output logic [SYLP_W-1:0] sense_q
);

    logic [WORD_W-1:0] mem_r [0:(1<<ADDR_W)-1];
    logic [SYLP_W-1:0] sense_r;
    logic [WORD_W-1:0] word_s;
    logic [WORD_W-1:0] upd_s;
    logic [SYLP_W-1:0] new_syl_s;

    // Build the updated word: sensing clears the syllable, writing replaces it.
    always_comb begin
        word_s = mem_r[addr];
        upd_s  = word_s;
        if (sense_en) begin
            new_syl_s = {SYLP_W{1'b0}};
        end else begin
            new_syl_s = wr_syl;
        end
        if (sel) begin
            upd_s[27:14] = new_syl_s;
        end else begin
            upd_s[13:0] = new_syl_s;
        end
    end

    // Array update on a sense (clear) or rewrite; other syllable untouched.
    always_ff @(posedge clk) begin
        if (sense_en || write_en) begin
            mem_r[addr] <= upd_s;
        end
    end

    // Capture the selected syllable before it is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sense_r <= {SYLP_W{1'b0}};
        end else if (sense_en) begin
            sense_r <= syl_slice(word_s, sel);
        end
    end

    assign sense_q = sense_r;

endmodule

// File: rtl/mem_duplex_module.sv
// Duplex core-memory responder: cycle FSM (IDLE/SENSE/STROBE/REWRITE),
// A/B selection with parity-based correction, scrub-on-read, error lines.
// Optional macro MEM_FAULT_INJ_EN adds FLTA/FLTB sense-bit-0 fault inputs.
module mem_duplex_module
    import mem_duplex_module_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              SYNC,
    input  logic              RD,
    input  logic              SYL0N,
    input  logic              SYL1N,
    input  logic              MAO,
    input  logic              MBO,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [12:0]       WD,
`ifdef MEM_FAULT_INJ_EN
    input  logic              FLTA,
    input  logic              FLTB,
`endif
    output logic [12:0]       SD,
    output logic              SDP,
    output logic              TIME,
    output logic              EAP,
    output logic              EBP,
    output logic              EAC,
    output logic              EBC,
    output logic              BUSY,
    output logic              SYLE
);

    state_e              state_r;
    logic                rd_r;
    logic                syl_r;
    logic                mao_r;
    logic                mbo_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [SYL_W-1:0]    wd_r;
    logic [SYL_W-1:0]    sd_r;
    logic                sdp_r;
    logic                time_r;
    logic                eap_r;
    logic                ebp_r;
    logic                eac_r;
    logic                busy_r;
    logic                syle_r;
    logic [SYLP_W-1:0]   rest_r;

    logic                flt_a_s;
    logic                flt_b_s;
    logic [SYLP_W-1:0]   sense_a_q;
    logic [SYLP_W-1:0]   sense_b_q;
    logic [SYLP_W-1:0]   a_s;
    logic [SYLP_W-1:0]   b_s;
    logic                a_ok_s;
    logic                b_ok_s;
    logic [SYLP_W-1:0]   sel_syl_s;
    logic [SYLP_W-1:0]   wr_syl_s;
    logic                sense_s;
    logic                rewrite_s;

`ifdef MEM_FAULT_INJ_EN
    logic flta_r;
    logic fltb_r;

    // Latch the fault-injection requests together with the cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            flta_r <= 1'b0;
            fltb_r <= 1'b0;
        end else if (state_r == ST_IDLE && SYNC && (SYL0N != SYL1N)) begin
            flta_r <= FLTA;
            fltb_r <= FLTB;
        end
    end

    assign flt_a_s = flta_r;
    assign flt_b_s = fltb_r;
`else
    assign flt_a_s = 1'b0;
    assign flt_b_s = 1'b0;
`endif

    assign sense_s   = (state_r == ST_SENSE);
    assign rewrite_s = (state_r == ST_REWRITE);

    // Read cycles restore the corrected syllable; stores write WD with parity.
    assign wr_syl_s = rd_r ? rest_r : {odd_parity(wd_r), wd_r};

    mem_core_bank #(.ADDR_W(ADDR_W)) u_bank_a (
        .clk      (CLK),
        .rst_n    (RSTN),
        .sense_en (sense_s & mao_r),
        .write_en (rewrite_s & mao_r),
        .sel      (syl_r),
        .addr     (addr_r),
        .wr_syl   (wr_syl_s),
        .sense_q  (sense_a_q)
    );

    mem_core_bank #(.ADDR_W(ADDR_W)) u_bank_b (
        .clk      (CLK),
        .rst_n    (RSTN),
        .sense_en (sense_s & mbo_r),
        .write_en (rewrite_s & mbo_r),
        .sel      (syl_r),
        .addr     (addr_r),
        .wr_syl   (wr_syl_s),
        .sense_q  (sense_b_q)
    );

    // Pick the syllable to deliver: good A, good B, raw A, raw B, else zero.
    always_comb begin
        a_s    = sense_a_q ^ {{(SYLP_W-1){1'b0}}, flt_a_s};
        b_s    = sense_b_q ^ {{(SYLP_W-1){1'b0}}, flt_b_s};
        a_ok_s = parity_ok(a_s);
        b_ok_s = parity_ok(b_s);
        if (mao_r && a_ok_s) begin
            sel_syl_s = a_s;
        end else if (mbo_r && b_ok_s) begin
            sel_syl_s = b_s;
        end else if (mao_r) begin
            sel_syl_s = a_s;
        end else if (mbo_r) begin
            sel_syl_s = b_s;
        end else begin
            sel_syl_s = {SYLP_W{1'b0}};
        end
    end

    // Cycle sequencing, request latching and registered outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= ST_IDLE;
            rd_r    <= 1'b0;
            syl_r   <= 1'b0;
            mao_r   <= 1'b0;
            mbo_r   <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wd_r    <= {SYL_W{1'b0}};
            sd_r    <= {SYL_W{1'b0}};
            sdp_r   <= 1'b0;
            time_r  <= 1'b0;
            eap_r   <= 1'b0;
            ebp_r   <= 1'b0;
            eac_r   <= 1'b0;
            busy_r  <= 1'b0;
            syle_r  <= 1'b0;
            rest_r  <= {SYLP_W{1'b0}};
        end else begin
            syle_r <= 1'b0;
            time_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (SYNC) begin
                        if (SYL0N == SYL1N) begin
                            syle_r <= 1'b1;
                        end else begin
                            rd_r    <= RD;
                            syl_r   <= ~SYL1N;
                            mao_r   <= MAO;
                            mbo_r   <= MBO;
                            addr_r  <= ADDR;
                            wd_r    <= WD;
                            busy_r  <= 1'b1;
                            state_r <= ST_SENSE;
                        end
                    end
                end
                ST_SENSE: begin
                    eap_r   <= 1'b0;
                    ebp_r   <= 1'b0;
                    eac_r   <= 1'b0;
                    state_r <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (rd_r) begin
                        sd_r   <= sel_syl_s[SYL_W-1:0];
                        sdp_r  <= sel_syl_s[SYLP_W-1];
                        time_r <= 1'b1;
                        eap_r  <= mao_r & ~a_ok_s;
                        ebp_r  <= mbo_r & ~b_ok_s;
                        eac_r  <= mao_r & mbo_r & a_ok_s & b_ok_s & (a_s != b_s);
                    end
                    rest_r  <= sel_syl_s;
                    state_r <= ST_REWRITE;
                end
                ST_REWRITE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign SD   = sd_r;
    assign SDP  = sdp_r;
    assign TIME = time_r;
    assign EAP  = eap_r;
    assign EBP  = ebp_r;
    assign EAC  = eac_r;
    assign EBC  = eac_r;
    assign BUSY = busy_r;
    assign SYLE = syle_r;

endmodule

// File: tb/tb_mem_duplex_module.sv
// Self-checking bench for mem_duplex_module: directed table, multi-cycle
// corner sequences and randomized cycles against a word-level memory model.
module tb_mem_duplex_module;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sync, rd, syl0n, syl1n, mao, mbo, flta, fltb;
    logic [7:0]  addr;
    logic [12:0] wd;
    logic [12:0] sd;
    logic        sdp, time_o, eap, ebp, eac, ebc, busy, syle;

    int checks = 0;
    int errors = 0;

    logic [27:0] mem_a [256];
    logic [27:0] mem_b [256];
    logic [12:0] last_sd;
    logic        last_sdp;

    always #5 clk = ~clk;

    mem_duplex_module #(.ADDR_W(8)) dut (
        .CLK   (clk),
        .RSTN  (rstn),
        .SYNC  (sync),
        .RD    (rd),
        .SYL0N (syl0n),
        .SYL1N (syl1n),
        .MAO   (mao),
        .MBO   (mbo),
        .ADDR  (addr),
        .WD    (wd),
`ifdef MEM_FAULT_INJ_EN
        .FLTA  (flta),
        .FLTB  (fltb),
`endif
        .SD    (sd),
        .SDP   (sdp),
        .TIME  (time_o),
        .EAP   (eap),
        .EBP   (ebp),
        .EAC   (eac),
        .EBC   (ebc),
        .BUSY  (busy),
        .SYLE  (syle)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Odd parity: the bit that brings the total count of ones to an odd number.
    function automatic logic par_bit(input logic [12:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic logic [13:0] get_syl(input logic [27:0] w, input logic s1);
        return 14'((w >> (s1 ? 14 : 0)) & 28'h3FFF);
    endfunction

    function automatic logic [27:0] put_syl(input logic [27:0] w, input logic s1,
                                            input logic [13:0] v);
        logic [27:0] mask;
        mask = 28'h3FFF << (s1 ? 14 : 0);
        return (w & ~mask) | (28'(v) << (s1 ? 14 : 0));
    endfunction

    // Reference model for one full memory cycle.
    task automatic model_op(input logic m_rd, input logic s1, input logic ma, input logic mb,
                            input logic [7:0] ad, input logic [12:0] d,
                            input logic fa, input logic fb,
                            output logic [12:0] e_sd, output logic e_sdp,
                            output logic e_eap, output logic e_ebp, output logic e_eac);
        logic [13:0] a, b, pick;
        logic aok, bok;
        e_eap = 1'b0; e_ebp = 1'b0; e_eac = 1'b0;
        if (m_rd) begin
            a = get_syl(mem_a[ad], s1) ^ {13'd0, fa};
            b = get_syl(mem_b[ad], s1) ^ {13'd0, fb};
            aok = ($countones(a) % 2) == 1;
            bok = ($countones(b) % 2) == 1;
            e_eap = ma && !aok;
            e_ebp = mb && !bok;
            e_eac = ma && mb && aok && bok && (a != b);
            if (ma && aok)      pick = a;
            else if (mb && bok) pick = b;
            else if (ma)        pick = a;
            else if (mb)        pick = b;
            else                pick = 14'd0;
            last_sd  = pick[12:0];
            last_sdp = pick[13];
        end else begin
            pick = {par_bit(d), d};
        end
        if (ma) mem_a[ad] = put_syl(mem_a[ad], s1, pick);
        if (mb) mem_b[ad] = put_syl(mem_b[ad], s1, pick);
        e_sd  = last_sd;
        e_sdp = last_sdp;
    endtask

    // Run one accepted cycle starting in IDLE, checking every phase.
    task automatic do_cyc(input logic c_rd, input logic s1, input logic ma, input logic mb,
                          input logic [7:0] ad, input logic [12:0] d,
                          input logic fa, input logic fb,
                          input logic [12:0] e_sd, input logic e_sdp,
                          input logic e_eap, input logic e_ebp, input logic e_eac);
        sync = 1'b1; rd = c_rd; syl0n = s1; syl1n = ~s1;
        mao = ma; mbo = mb; addr = ad; wd = d; flta = fa; fltb = fb;
        @(posedge clk); #1;
        sync = 1'b0;
        chk("busy_sense", busy, 1'b1);
        @(posedge clk); #1;
        chk("time_strobe0", time_o, 1'b0);
        chk("err_cleared", {eap, ebp, eac, ebc}, 4'b0000);
        @(posedge clk); #1;
        chk("time_valid", time_o, c_rd);
        chk("sd", sd, e_sd);
        chk("sdp", sdp, e_sdp);
        chk("eap", eap, e_eap);
        chk("ebp", ebp, e_ebp);
        chk("eac", eac, e_eac);
        chk("ebc", ebc, e_eac);
        chk("busy_rewrite", busy, 1'b1);
        @(posedge clk); #1;
        chk("time_one_cycle", time_o, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("sd_hold", sd, e_sd);
    endtask

    typedef struct {
        logic        rd;
        logic        s1;
        logic        ma;
        logic        mb;
        logic [7:0]  ad;
        logic [12:0] d;
        logic [12:0] e_sd;
        logic        e_sdp;
        logic        e_eap;
        logic        e_ebp;
        logic        e_eac;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [12:0] e_sd;
        logic        e_sdp, e_eap, e_ebp, e_eac;

        rstn = 1'b0; sync = 1'b0; rd = 1'b0; syl0n = 1'b0; syl1n = 1'b1;
        mao = 1'b0; mbo = 1'b0; addr = 8'd0; wd = 13'd0; flta = 1'b0; fltb = 1'b0;
        last_sd = 13'd0; last_sdp = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sd", sd, 13'd0);
        chk("rst_sdp", sdp, 1'b0);
        chk("rst_time", time_o, 1'b0);
        chk("rst_err", {eap, ebp, eac, ebc}, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_syle", syle, 1'b0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed table. 0x1ABC has 8 ones -> parity bit 1; 0x0123 has 4 -> 1.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 13'h1ABC, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 13'h0000, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 13'h0123, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 13'h0000, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 13'h0000, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 13'h0000, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 13'h0000, 13'h1ABC, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            do_cyc(tbl[i].rd, tbl[i].s1, tbl[i].ma, tbl[i].mb, tbl[i].ad, tbl[i].d,
                   1'b0, 1'b0, tbl[i].e_sd, tbl[i].e_sdp,
                   tbl[i].e_eap, tbl[i].e_ebp, tbl[i].e_eac);
        end
        last_sd  = tbl[6].e_sd;
        last_sdp = tbl[6].e_sdp;

        // Initialise model and DUT for addresses 0..15, both syllables
        for (int a = 0; a < 16; a++) begin
            mem_a[a] = 28'd0;
            mem_b[a] = 28'd0;
            for (int s = 0; s < 2; s++) begin
                logic [12:0] v;
                v = 13'($urandom);
                model_op(1'b0, s[0], 1'b1, 1'b1, 8'(a), v, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
                do_cyc(1'b0, s[0], 1'b1, 1'b1, 8'(a), v, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
            end
        end

        // Illegal syllable select: SYLE pulse, no cycle started
        sync = 1'b1; syl0n = 1'b0; syl1n = 1'b0; rd = 1'b0; mao = 1'b1; mbo = 1'b1;
        addr = 8'd2; wd = 13'h1FFF;
        @(posedge clk); #1;
        sync = 1'b0;
        chk("syle_pulse", syle, 1'b1);
        chk("syle_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("syle_one_cycle", syle, 1'b0);
        chk("syle_busy2", busy, 1'b0);
        model_op(1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        do_cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);

        // SYNC held high: syllable-1 stores accepted every 4 clocks
        sync = 1'b1; rd = 1'b0; syl0n = 1'b1; syl1n = 1'b0; mao = 1'b1; mbo = 1'b1;
        addr = 8'd9; wd = 13'h0F0F;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            if (j == 11) sync = 1'b0;
            chk("sync_held_busy", busy, ((j % 4) != 3));
            chk("sync_held_time", time_o, 1'b0);
        end
        for (int j = 0; j < 3; j++) begin
            model_op(1'b0, 1'b1, 1'b1, 1'b1, 8'd9, 13'h0F0F, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        end
        for (int s = 0; s < 2; s++) begin
            model_op(1'b1, s[0], 1'b1, 1'b1, 8'd9, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
            do_cyc(1'b1, s[0], 1'b1, 1'b1, 8'd9, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        end
        chk("syl1_store_value", sd, 13'h0F0F);

        // Reset during STROBE of a read leaves the syllable destroyed
        model_op(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 13'h0555, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        do_cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 13'h0555, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        model_op(1'b1, 1'b0, 1'b1, 1'b1, 8'd7, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        do_cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd7, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        sync = 1'b1; rd = 1'b1; syl0n = 1'b0; syl1n = 1'b1; mao = 1'b1; mbo = 1'b1; addr = 8'd7;
        @(posedge clk); #1;
        sync = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("strobe_rst_sd", sd, 13'd0);
        chk("strobe_rst_sdp", sdp, 1'b0);
        chk("strobe_rst_time", time_o, 1'b0);
        chk("strobe_rst_busy", busy, 1'b0);
        chk("strobe_rst_err", {eap, ebp, eac, ebc}, 4'b0000);
        #3;
        rstn = 1'b1;
        @(posedge clk); #1;
        mem_a[7] = put_syl(mem_a[7], 1'b0, 14'd0);
        mem_b[7] = put_syl(mem_b[7], 1'b0, 14'd0);
        last_sd = 13'd0; last_sdp = 1'b0;
        model_op(1'b1, 1'b0, 1'b1, 1'b1, 8'd7, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        do_cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd7, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        chk("zero_syl_both_bad", {eap, ebp}, 2'b11);

`ifdef MEM_FAULT_INJ_EN
        // Fault on A: B supplies the data, the scrub restores A
        model_op(1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 13'd0, 1'b1, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        do_cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 13'd0, 1'b1, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        chk("flta_eap", eap, 1'b1);
        model_op(1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        do_cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 13'd0, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        chk("flta_scrubbed", eap, 1'b0);
`endif

        // Randomized cycles against the model
        for (int n = 0; n < 150; n++) begin
            logic r_rd, r_s1, r_ma, r_mb;
            logic [7:0]  r_ad;
            logic [12:0] r_d;
            r_rd = 1'($urandom_range(0, 1));
            r_s1 = 1'($urandom_range(0, 1));
            r_ma = ($urandom_range(0, 3) != 0);
            r_mb = ($urandom_range(0, 3) != 0);
            r_ad = 8'($urandom_range(0, 15));
            r_d  = 13'($urandom);
            model_op(r_rd, r_s1, r_ma, r_mb, r_ad, r_d, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
            do_cyc(r_rd, r_s1, r_ma, r_mb, r_ad, r_d, 1'b0, 1'b0, e_sd, e_sdp, e_eap, e_ebp, e_eac);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
